// File: rtl/emergency_preempt_arbiter.sv
// rtl/emergency_preempt_arbiter.sv - debounced round-robin emergency vehicle preemption arbiter
module emergency_preempt_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_HOLD        = 8,
    parameter int MAX_HOLD        = 64,
    parameter int CLEAR_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ev_detect,
    input  logic       ev_enable,
    output logic       emergency_vehicle,
    output logic [1:0] emergency_road,
    output logic [3:0] req_pending,
    output logic       busy,
    output logic       timeout
);

    // Counter widths cover the largest value each counter is allowed to hold.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES + 1) : 1;

    // Counters store "cycles completed before this one", so the terminal
    // values are one less than the cycle budgets.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] MIN_LAST  = HOLD_W'(MIN_HOLD - 1);
    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [3:0]          sync_q1;
    logic [3:0]          sync_q2;
    logic [DB_W-1:0]     db_cnt [4];
    logic [3:0]          lockout;
    logic [1:0]          last_granted;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [CLR_W-1:0]    clr_cnt;

    logic [3:0]          eligible;
    logic                rr_found;
    logic [1:0]          rr_road;
    logic [1:0]          rr_cand;
    logic                take_grant;
    logic                hit_timeout;

    // Two-flop synchronizer on the raw detector inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= ev_detect;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: a bit flips only after DEBOUNCE_CYCLES consecutive opposite samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pending <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] != req_pending[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        req_pending[i] <= sync_q2[i];
                        db_cnt[i]      <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Round-robin search starting one past the last granted road.
    always_comb begin
        eligible = req_pending & ~lockout;
        rr_found = 1'b0;
        rr_road  = '0;
        rr_cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = last_granted + 2'(k);
            if (!rr_found && eligible[rr_cand]) begin
                rr_found = 1'b1;
                rr_road  = rr_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; disable beats timeout, timeout beats a normal release.
    always_comb begin
        state_next  = state;
        take_grant  = 1'b0;
        hit_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev_enable && rr_found) begin
                    state_next = ST_GRANT;
                    take_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!ev_enable) begin
                    state_next = ST_CLEAR;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next  = ST_CLEAR;
                    hit_timeout = 1'b1;
                end else if ((hold_cnt >= MIN_LAST) && !req_pending[emergency_road]) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Hold/clear counters restart on every entry into their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            clr_cnt  <= '0;
        end else begin
            if ((state == ST_GRANT) && (state_next == ST_GRANT)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
            if ((state == ST_CLEAR) && (state_next == ST_CLEAR)) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // Grant bookkeeping: latched road, round-robin pointer, timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            emergency_road <= '0;
            last_granted   <= 2'd3;
            timeout        <= 1'b0;
        end else begin
            timeout <= hit_timeout;
            if (take_grant) begin
                emergency_road <= rr_road;
                last_granted   <= rr_road;
            end
        end
    end

    // A timed-out road stays locked until its debounced request drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            lockout <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                lockout[i] <= (lockout[i] | (hit_timeout && (emergency_road == 2'(i))))
                              & req_pending[i];
            end
        end
    end

    assign emergency_vehicle = (state == ST_GRANT);
    assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// tb/tb_emergency_preempt_arbiter.sv - randomized model-checked bench for emergency_preempt_arbiter
module tb_emergency_preempt_arbiter;

    localparam int DB   = 4;
    localparam int MINH = 8;
    localparam int MAXH = 64;
    localparam int CLR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ev_detect = '0;
    logic       ev_enable = 1'b1;
    logic       emergency_vehicle;
    logic [1:0] emergency_road;
    logic [3:0] req_pending;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    emergency_preempt_arbiter #(
        .DEBOUNCE_CYCLES(DB),
        .MIN_HOLD(MINH),
        .MAX_HOLD(MAXH),
        .CLEAR_CYCLES(CLR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ev_detect(ev_detect),
        .ev_enable(ev_enable),
        .emergency_vehicle(emergency_vehicle),
        .emergency_road(emergency_road),
        .req_pending(req_pending),
        .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model state (updated once per rising edge).
    bit [3:0] m_ev_d1, m_ev_d2;
    bit [3:0] m_samples[$];
    bit [3:0] m_pend;
    int       m_mode;       // 0 idle, 1 grant, 2 clear
    int       m_in_mode;    // cycles already completed in current mode
    int       m_road;
    int       m_last;
    bit [3:0] m_lock;
    bit       m_tmo;
    int       m_timeouts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 25)
                $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ev_d1 = '0; m_ev_d2 = '0;
        m_samples.delete();
        m_pend = '0; m_mode = 0; m_in_mode = 0;
        m_road = 0; m_last = 3; m_lock = '0; m_tmo = 0;
    endtask

    task automatic model_edge();
        bit [3:0] sample;
        bit [3:0] new_pend;
        bit [3:0] new_lock;
        int       new_mode;
        bit       new_tmo;
        int       elapsed;
        if (rst) begin
            model_reset();
            return;
        end
        sample  = m_ev_d2;
        m_ev_d2 = m_ev_d1;
        m_ev_d1 = ev_detect;

        new_mode = m_mode;
        new_tmo  = 0;
        elapsed  = m_in_mode + 1;
        if (m_mode == 0) begin
            if (ev_enable) begin
                for (int k = 1; k <= 4; k++) begin
                    int r;
                    r = (m_last + k) % 4;
                    if (new_mode == 0 && m_pend[r] && !m_lock[r]) begin
                        new_mode = 1;
                        m_road   = r;
                        m_last   = r;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (!ev_enable) new_mode = 2;
            else if (elapsed == MAXH) begin new_mode = 2; new_tmo = 1; end
            else if (elapsed >= MINH && !m_pend[m_road]) new_mode = 2;
        end else begin
            if (elapsed == CLR) new_mode = 0;
        end

        for (int i = 0; i < 4; i++)
            new_lock[i] = (m_lock[i] | (m_tmo_set(new_tmo, i))) & m_pend[i];

        // Debounce: flip when the last DB synchronized samples all disagree.
        m_samples.push_back(sample);
        if (m_samples.size() > DB) void'(m_samples.pop_front());
        new_pend = m_pend;
        if (m_samples.size() == DB) begin
            for (int i = 0; i < 4; i++) begin
                bit all_opp;
                all_opp = 1;
                foreach (m_samples[j]) if (m_samples[j][i] == m_pend[i]) all_opp = 0;
                if (all_opp) new_pend[i] = ~m_pend[i];
            end
        end

        m_in_mode = (new_mode == m_mode) ? m_in_mode + 1 : 0;
        m_mode    = new_mode;
        m_tmo     = new_tmo;
        m_lock    = new_lock;
        m_pend    = new_pend;
        if (new_tmo) m_timeouts++;
    endtask

    function automatic bit m_tmo_set(input bit t, input int i);
        return t && (m_road == i);
    endfunction

    task automatic step(input logic [3:0] ev, input logic en, input logic r);
        ev_detect = ev;
        ev_enable = en;
        rst       = r;
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
        check("emergency_vehicle", 32'(emergency_vehicle), 32'(m_mode == 1));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("emergency_road", 32'(emergency_road), 32'(m_road));
        check("req_pending", 32'(req_pending), 32'(m_pend));
        check("timeout", 32'(timeout), 32'(m_tmo));
    endtask

    initial begin
        logic [3:0] ev;
        logic       en;
        int         t0;
        model_reset();
        m_timeouts = 0;

        // Reset state.
        repeat (3) step(4'b0000, 1'b1, 1'b1);

        // Single road 0 request: pending after 5 edges, grant after 6.
        for (int i = 0; i < 20; i++) step(4'b0001, 1'b1, 1'b0);
        repeat (20) step(4'b0000, 1'b1, 1'b0);

        // Short glitch on road 2 must not qualify.
        repeat (3) step(4'b0100, 1'b1, 1'b0);
        repeat (12) step(4'b0000, 1'b1, 1'b0);
        check("glitch_no_grant_road", 32'(m_pend), 32'h0);

        // Simultaneous roads 1 and 3 after reset.
        repeat (2) step(4'b0000, 1'b1, 1'b1);
        repeat (12) step(4'b1010, 1'b1, 1'b0);
        repeat (12) step(4'b1000, 1'b1, 1'b0);
        repeat (30) step(4'b0000, 1'b1, 1'b0);

        // Early release of road 0 still holds MIN_HOLD.
        repeat (8) step(4'b0001, 1'b1, 1'b0);
        repeat (25) step(4'b0000, 1'b1, 1'b0);

        // Road 2 held: one timeout, lockout until it drops.
        t0 = m_timeouts;
        repeat (120) step(4'b0100, 1'b1, 1'b0);
        check("timeout_count", 32'(m_timeouts - t0), 32'd1);
        repeat (15) step(4'b0000, 1'b1, 1'b0);
        repeat (20) step(4'b0100, 1'b1, 1'b0);
        repeat (20) step(4'b0000, 1'b1, 1'b0);

        // Reset mid-grant, then enable dropped mid-grant.
        repeat (10) step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        repeat (10) step(4'b0010, 1'b1, 1'b0);
        repeat (3) step(4'b0010, 1'b0, 1'b0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);

        // Random traffic with persistent detectors, enable drops and rare resets.
        ev = '0;
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) ev[b] = ~ev[b];
            if ($urandom_range(0, 59) == 0) en = ~en;
            if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
            step(ev, en, ($urandom_range(0, 799) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/emergency_preempt_arbiter.md
EMERGENCY_PREEMPT_ARBITER -- requirements
Module: emergency_preempt_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles needed to qualify or drop a detector request.
REQ-002 Parameter MIN_HOLD, default 8: minimum cycles a grant stays asserted.
REQ-003 Parameter MAX_HOLD, default 64: maximum cycles of one grant; timeout at this count.
REQ-004 Parameter CLEAR_CYCLES, default 2: all-clear gap between consecutive grants.
REQ-005 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port ev_detect, input, 4: raw asynchronous emergency detectors; bit i is road i.
REQ-008 Port ev_enable, input, 1: global preemption enable.
REQ-009 Port emergency_vehicle, output, 1: preemption request to the traffic light controller.
REQ-010 Port emergency_road, output, 2: granted road index, valid while emergency_vehicle=1.
REQ-011 Port req_pending, output, 4: debounced, qualified requests.
REQ-012 Port busy, output, 1: high in GRANT or CLEAR.
REQ-013 Port timeout, output, 1: one-cycle pulse when a grant is ended by MAX_HOLD.

Function
REQ-014 Each ev_detect bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-015 req_pending[i] SHALL set after DEBOUNCE_CYCLES consecutive synchronized-high samples and clear after DEBOUNCE_CYCLES consecutive synchronized-low samples; shorter glitches are ignored.
REQ-016 With ev_detect[i] held high from before edge k, req_pending[i] SHALL be 1 after edge k+DEBOUNCE_CYCLES+1 and emergency_vehicle 1 after edge k+DEBOUNCE_CYCLES+2 (IDLE, enabled, not locked out).
REQ-017 States SHALL be IDLE, GRANT, CLEAR; reset state IDLE.
REQ-018 IDLE -> GRANT when ev_enable=1 and any unlocked req_pending bit is set; road chosen round-robin starting at (last_granted+1) mod 4.
REQ-019 last_granted SHALL reset to 3, so road 0 has first priority after reset.
REQ-020 On entering GRANT, emergency_vehicle=1, emergency_road latched, hold counter cleared; emergency_road SHALL not change during GRANT.
REQ-021 GRANT -> CLEAR when hold count >= MIN_HOLD and req_pending[granted]=0.
REQ-022 GRANT -> CLEAR when hold count reaches MAX_HOLD regardless of request; timeout pulses 1 cycle on that edge; the road is locked out until its req_pending clears.
REQ-023 GRANT -> CLEAR on the next edge when ev_enable=0, overriding MIN_HOLD; timeout not pulsed.
REQ-024 In CLEAR, emergency_vehicle=0, emergency_road holds last value; after CLEAR_CYCLES cycles -> IDLE.
REQ-025 Requests from other roads arriving during GRANT or CLEAR SHALL stay pending and be arbitrated in IDLE; no grant-to-grant transition without CLEAR.
REQ-026 In IDLE with ev_enable=0, no grant is issued; debouncing continues.
REQ-027 Hold and clear counters SHALL be sized for MAX_HOLD and CLEAR_CYCLES with no wrap.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, emergency_vehicle=0, emergency_road=0, req_pending=0, busy=0, timeout=0, synchronizers/debounce counters/lockouts cleared, last_granted=3, including mid-grant.

Verification (defaults)
REQ-029 ev_detect=0001 set before edge 10, held -> req_pending=0001 after edge 15, emergency_vehicle=1, emergency_road=00 after edge 16.
REQ-030 ev_detect[2] high for 3 cycles then low -> req_pending stays 0000, no grant.
REQ-031 ev_detect=1010 simultaneously after reset -> grant road 1 first; after it drops, MIN_HOLD met and 2 clear cycles, grant road 3.
REQ-032 Road 0 request released after 2 granted cycles -> emergency_vehicle stays 1 until 8 grant cycles, then 2 cycles low, busy low after.
REQ-033 Road 2 held high continuously -> grant ends after 64 cycles with one timeout pulse; no regrant of road 2 until detector low for debounce time.
REQ-034 rst asserted mid-grant, and ev_enable dropped mid-grant (separate runs) -> all outputs 0 after next edge, and CLEAR entered next edge without timeout, respectively.
